count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Sequence checker that sits on the consumer side of a binary up-counter such as `counter`. It samples a counter value stream and locks onto the increment-by-one sequence. Once locked, it flags every break in the sequence, including the legal wrap from all-ones to zero, and keeps saturating error and wrap statistics. It is used in-system as a health monitor and on benches as a reusable scoreboard in place of single end-of-test value checks.

## Interface
- `WIDTH`, 4: width of the observed count.
- `LOCK_COUNT`, 3: consecutive correct increments required to declare lock; range 1..15.
- `ERR_W`, 8: width of the error and wrap statistic counters.

One clock; reset is asynchronous and active-low.

- `clk`: input, 1 bit. Rising-edge clock.
- `rst_n`: input, 1 bit. Asynchronous active-low reset.
- `valid`: input, 1 bit. `count_in` is sampled on the rising edge when high.
- `count_in`: input, WIDTH bits. Observed counter value.
- `clear`: input, 1 bit. Synchronous; clears statistics and returns to HUNT.
- `locked`: output, 1 bit. High while in LOCKED.
- `mismatch`: output, 1 bit. One-cycle pulse on a sequence break while LOCKED.
- `expected`: output, WIDTH bits. Value expected for the next sample.
- `err_cnt`: output, ERR_W bits. Saturating count of mismatches.
- `wrap_cnt`: output, ERR_W bits. Saturating count of legal wraps seen while LOCKED.

## Operation
- The FSM has three states: HUNT, ACQUIRE and LOCKED. Reset state is HUNT.
- **HUNT:**
  - On `valid`: `expected` ← `count_in`+1 (mod 2^WIDTH).
  - good-run counter ← 0.
  - Go to ACQUIRE.
- **ACQUIRE:**
  - **Sample equals `expected`:** increment the good-run counter and advance `expected`.
  - **Run reaches `LOCK_COUNT`:** go to LOCKED.
  - **Sample differs:** re-reference with `expected` ← `count_in`+1 and good-run ← 0.
  - Mismatches in ACQUIRE do not pulse `mismatch` and are not added to `err_cnt`.
- **LOCKED:**
  - **Sample equals `expected`:** advance `expected`.
  - **Legal wrap:** if the sample is 0 and the previous value was all-ones, increment `wrap_cnt`.
  - **Sample differs:**
    - Pulse `mismatch`.
    - Increment `err_cnt`.
    - Re-reference with `expected` ← `count_in`+1 and good-run ← 0.
    - Go to ACQUIRE.
- **Arithmetic:** all increments of the count are modulo 2^WIDTH. `err_cnt` and `wrap_cnt` saturate at 2^ERR_W−1 and never wrap.
- **`clear`:**
  - Sets `err_cnt`, `wrap_cnt` and good-run to 0 and the state to HUNT.
  - `expected` holds its value.
  - When `clear` and `valid` are high together, `clear` wins and the sample is discarded.
- **`valid` low:** no state change; `mismatch` is 0.

## Timing
- All outputs are registered. `mismatch`, `locked`, `expected` and the counters update on the edge that samples `count_in`, so they are visible one cycle after the sample is presented.
- `mismatch` is high for exactly one cycle per offending sample. Back-to-back bad samples cannot give back-to-back pulses, because the first bad sample leaves LOCKED.
- `locked` falls in the same cycle that `mismatch` rises.
- `locked` rises on the edge that samples the `LOCK_COUNT`-th consecutive correct value after the reference sample.
- **Reset values:** `locked`=0, `mismatch`=0, `expected`=0, `err_cnt`=0, `wrap_cnt`=0, state HUNT.
- **Reset mid-operation:** asserting `rst_n` low forces all of the above immediately, with no clock needed. Statistics are lost.

## Configuration
- **`COUNT_SEQ_CHECKER_STALL_EN` defined:** a sample equal to the previous sample (that is, `expected`−1) is a legal hold, for a counter paused by an enable.
  - In ACQUIRE: no state, run or `expected` change.
  - In LOCKED: no mismatch, no state change, no `expected` change.
- **Macro not defined:** a repeated value is an ordinary sequence break and is handled as in Operation.

## Test plan
All scenarios use default parameters unless noted.
- **Lock-up:** release reset, then feed `valid` each cycle with 0,1,2,3,4. `locked` rises one cycle after sample 3 is presented. `expected`=5 after sample 4, `err_cnt`=0, `mismatch` never high.
- **Wrap:** while locked, feed 13,14,15,0,1. No mismatch, `wrap_cnt`=1, `expected`=2.
- **Break and relock:** while locked with `expected`=6, feed 9.
  - Next cycle: `mismatch`=1 for one cycle, `locked`=0, `err_cnt`=1, `expected`=10.
  - Then feed 10,11,12: `locked`=1 again and `err_cnt` stays 1.
- **Hold:** while locked, feed 7,7,8.
  - With `COUNT_SEQ_CHECKER_STALL_EN`: no mismatch and `locked` stays 1.
  - Without the macro: mismatch on the second 7, `err_cnt`+1, `locked`=0.
- **Saturation:** set `ERR_W`=2 and `LOCK_COUNT`=1, then force 5 lock/break cycles. `err_cnt` reads 1,2,3,3,3.
- **Clear and reset:**
  - While locked, assert `clear` together with `valid` and `count_in`=3. The sample is ignored; next cycle `locked`=0, `err_cnt`=0, `wrap_cnt`=0.
  - Drop `rst_n` between clock edges. All outputs go to reset values before the next edge.

Source files
------------

// File: rtl/count_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : count_seq_checker                                             |
// | Purpose  : Consumer-side monitor for a binary up-counter. Locks onto the |
// |            increment-by-one sequence, flags every break while locked and |
// |            keeps saturating error / legal-wrap statistics.               |
// | Ports    : clk, rst_n      - clock, async active-low reset               |
// |            valid, count_in - sample strobe and observed counter value    |
// |            clear           - sync clear of statistics, back to HUNT      |
// |            locked          - high while in LOCKED                        |
// |            mismatch        - one-cycle pulse on a break while LOCKED     |
// |            expected        - value expected for the next sample          |
// |            err_cnt         - saturating mismatch count                   |
// |            wrap_cnt        - saturating legal-wrap count (LOCKED only)   |
// | Options  : COUNT_SEQ_CHECKER_STALL_EN - a repeat of the previous value   |
// |            is accepted as a legal hold (paused counter).                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module count_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] wrap_q, wrap_d;
  logic             mismatch_q, mismatch_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] ref_next;
  logic [WIDTH-1:0] exp_next;
  logic [3:0]       run_inc;
  logic             match;
  logic             hold_sample;

  assign ref_next = count_in + WIDTH'(1);
  assign exp_next = expected_q + WIDTH'(1);
  assign run_inc  = run_q + 4'd1;
  assign match    = (count_in == expected_q);

`ifdef COUNT_SEQ_CHECKER_STALL_EN
  // expected-1 is the last accepted value; repeating it means a paused counter.
  assign hold_sample = (count_in == (expected_q - WIDTH'(1)));
`else
  assign hold_sample = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    expected_d = expected_q;
    err_d      = err_q;
    wrap_d     = wrap_q;
    mismatch_d = 1'b0;

    if (clear) begin
      // clear has priority over a coincident sample; expected is kept.
      state_d = HUNT;
      run_d   = 4'd0;
      err_d   = '0;
      wrap_d  = '0;
    end else if (valid) begin
      case (state_q)
        HUNT: begin
          expected_d = ref_next;
          run_d      = 4'd0;
          state_d    = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            run_d      = run_inc;
            expected_d = exp_next;
            if (run_inc == 4'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end
          end else if (!hold_sample) begin
            expected_d = ref_next;
            run_d      = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_d = exp_next;
            // A matching zero can only follow all-ones: that is the legal wrap.
            if ((count_in == '0) && !(&wrap_q)) begin
              wrap_d = wrap_q + ERR_W'(1);
            end
          end else if (!hold_sample) begin
            mismatch_d = 1'b1;
            if (!(&err_q)) begin
              err_d = err_q + ERR_W'(1);
            end
            expected_d = ref_next;
            run_d      = 4'd0;
            state_d    = ACQUIRE;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      run_q      <= 4'd0;
      expected_q <= '0;
      err_q      <= '0;
      wrap_q     <= '0;
      mismatch_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      mismatch_q <= mismatch_d;
      locked_q   <= locked_d;
    end
  end

  assign locked   = locked_q;
  assign mismatch = mismatch_q;
  assign expected = expected_q;
  assign err_cnt  = err_q;
  assign wrap_cnt = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_count_seq_checker                                          |
// | Purpose  : Directed self-checking bench for count_seq_checker. A default |
// |            instance covers lock-up, wrap, break/relock, hold, clear and  |
// |            async reset; a second instance (ERR_W=2, LOCK_COUNT=1) covers |
// |            error-counter saturation.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_count_seq_checker;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [3:0] count_in;
  logic       clear;
  logic       locked;
  logic       mismatch;
  logic [3:0] expected;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  logic       s_valid;
  logic [3:0] s_count_in;
  logic       s_clear;
  logic       s_locked;
  logic       s_mismatch;
  logic [3:0] s_expected;
  logic [1:0] s_err_cnt;
  logic [1:0] s_wrap_cnt;

  int n_cmp;
  int n_err;

  count_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .count_in (count_in),
    .clear    (clear),
    .locked   (locked),
    .mismatch (mismatch),
    .expected (expected),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  count_seq_checker #(.WIDTH(4), .LOCK_COUNT(1), .ERR_W(2)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (s_valid),
    .count_in (s_count_in),
    .clear    (s_clear),
    .locked   (s_locked),
    .mismatch (s_mismatch),
    .expected (s_expected),
    .err_cnt  (s_err_cnt),
    .wrap_cnt (s_wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
    n_cmp++;
    assert (obs === exv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
    end
  endtask

  // Drive on the falling edge, then settle just after the sampling edge.
  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    @(negedge clk);
    valid    = v;
    count_in = c;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic [3:0] c);
    @(negedge clk);
    s_valid    = 1'b1;
    s_count_in = c;
    s_clear    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    valid      = 1'b0;
    count_in   = 4'd0;
    clear      = 1'b0;
    s_valid    = 1'b0;
    s_count_in = 4'd0;
    s_clear    = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    chk("rst_err",      32'(err_cnt),  32'd0);
    chk("rst_wrap",     32'(wrap_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock-up: 0,1,2,3,4
    step(1'b1, 4'd0, 1'b0);
    chk("lk0_expected", 32'(expected), 32'd1);
    chk("lk0_locked",   32'(locked),   32'd0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    chk("lk2_locked",   32'(locked),   32'd0);
    step(1'b1, 4'd3, 1'b0);
    chk("lk3_locked",   32'(locked),   32'd1);
    chk("lk3_mismatch", 32'(mismatch), 32'd0);
    step(1'b1, 4'd4, 1'b0);
    chk("lk4_expected", 32'(expected), 32'd5);
    chk("lk4_err",      32'(err_cnt),  32'd0);
    chk("lk4_mismatch", 32'(mismatch), 32'd0);

    // Break and relock: expected=6 then feed 9
    step(1'b1, 4'd5, 1'b0);
    chk("brk_pre_exp",  32'(expected), 32'd6);
    step(1'b1, 4'd9, 1'b0);
    chk("brk_mismatch", 32'(mismatch), 32'd1);
    chk("brk_locked",   32'(locked),   32'd0);
    chk("brk_err",      32'(err_cnt),  32'd1);
    chk("brk_expected", 32'(expected), 32'd10);
    step(1'b1, 4'd10, 1'b0);
    chk("brk_pulse1",   32'(mismatch), 32'd0);
    step(1'b1, 4'd11, 1'b0);
    step(1'b1, 4'd12, 1'b0);
    chk("rlk_locked",   32'(locked),   32'd1);
    chk("rlk_err",      32'(err_cnt),  32'd1);
    chk("rlk_expected", 32'(expected), 32'd13);

    // Wrap: 13,14,15,0,1
    step(1'b1, 4'd13, 1'b0);
    step(1'b1, 4'd14, 1'b0);
    step(1'b1, 4'd15, 1'b0);
    chk("wrp_pre_cnt",  32'(wrap_cnt), 32'd0);
    step(1'b1, 4'd0, 1'b0);
    chk("wrp_mismatch", 32'(mismatch), 32'd0);
    step(1'b1, 4'd1, 1'b0);
    chk("wrp_cnt",      32'(wrap_cnt), 32'd1);
    chk("wrp_expected", 32'(expected), 32'd2);
    chk("wrp_locked",   32'(locked),   32'd1);

    // valid low: nothing moves
    step(1'b0, 4'd15, 1'b0);
    chk("idle_expected", 32'(expected), 32'd2);
    chk("idle_locked",   32'(locked),   32'd1);
    chk("idle_mismatch", 32'(mismatch), 32'd0);

    // Hold: advance to expected=7, then 7,7,8
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    chk("hld_exp8", 32'(expected), 32'd8);
    step(1'b1, 4'd7, 1'b0);
`ifdef COUNT_SEQ_CHECKER_STALL_EN
    chk("hld_mismatch", 32'(mismatch), 32'd0);
    chk("hld_locked",   32'(locked),   32'd1);
    chk("hld_expected", 32'(expected), 32'd8);
    chk("hld_err",      32'(err_cnt),  32'd1);
    step(1'b1, 4'd8, 1'b0);
    chk("hld8_locked",  32'(locked),   32'd1);
`else
    chk("hld_mismatch", 32'(mismatch), 32'd1);
    chk("hld_locked",   32'(locked),   32'd0);
    chk("hld_expected", 32'(expected), 32'd8);
    chk("hld_err",      32'(err_cnt),  32'd2);
    step(1'b1, 4'd8, 1'b0);
    chk("hld8_locked",  32'(locked),   32'd0);
`endif
    chk("hld8_expected", 32'(expected), 32'd9);
    step(1'b1, 4'd9, 1'b0);
    step(1'b1, 4'd10, 1'b0);
    chk("hld_relock",   32'(locked),   32'd1);
    chk("hld_exp11",    32'(expected), 32'd11);

    // Clear wins over a coincident sample; expected holds
    step(1'b1, 4'd3, 1'b1);
    chk("clr_locked",   32'(locked),   32'd0);
    chk("clr_err",      32'(err_cnt),  32'd0);
    chk("clr_wrap",     32'(wrap_cnt), 32'd0);
    chk("clr_expected", 32'(expected), 32'd11);
    chk("clr_mismatch", 32'(mismatch), 32'd0);

    // Re-acquire from HUNT, lock, then break to load statistics
    step(1'b1, 4'd4, 1'b0);
    chk("hunt_expected", 32'(expected), 32'd5);
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    chk("re_locked",    32'(locked),   32'd1);
    step(1'b1, 4'd0, 1'b0);
    chk("re_mismatch",  32'(mismatch), 32'd1);
    chk("re_err",       32'(err_cnt),  32'd1);
    chk("re_expected",  32'(expected), 32'd1);
    step(1'b0, 4'd0, 1'b0);

    // Saturation: ERR_W=2, LOCK_COUNT=1
    sstep(4'd0);
    sstep(4'd1);
    chk("sat_lock0",    32'(s_locked),  32'd1);
    sstep(4'd5);
    chk("sat_err1",     32'(s_err_cnt), 32'd1);
    sstep(4'd6);
    chk("sat_lock1",    32'(s_locked),  32'd1);
    sstep(4'd10);
    chk("sat_err2",     32'(s_err_cnt), 32'd2);
    sstep(4'd11);
    sstep(4'd0);
    chk("sat_err3",     32'(s_err_cnt), 32'd3);
    sstep(4'd1);
    sstep(4'd5);
    chk("sat_err4",     32'(s_err_cnt), 32'd3);
    chk("sat_mismatch", 32'(s_mismatch), 32'd1);
    sstep(4'd6);
    sstep(4'd10);
    chk("sat_err5",     32'(s_err_cnt), 32'd3);

    // Async reset between edges: put the default instance in a busy state first
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    chk("pre_rst_mismatch", 32'(mismatch), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked",   32'(locked),   32'd0);
    chk("arst_mismatch", 32'(mismatch), 32'd0);
    chk("arst_expected", 32'(expected), 32'd0);
    chk("arst_err",      32'(err_cnt),  32'd0);
    chk("arst_wrap",     32'(wrap_cnt), 32'd0);
    chk("arst_s_err",    32'(s_err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
